// File: rtl/rotr_seq_pkg.sv
// Shared ALU definitions for the multi-cycle rotate-right unit.
//   ROTR_WIDTH   : operand/result width
//   ROTR_AMT_W   : rotate-amount bits, log2(ROTR_WIDTH)
//   rotr_state_e : control FSM encoding; 2'd3 is unused and recovers to IDLE
package rotr_seq_pkg;

    localparam int unsigned ROTR_WIDTH = 32;
    localparam int unsigned ROTR_AMT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } rotr_state_e;

endpackage

// File: rtl/rotr_stage.sv
// One stage of the logarithmic rotator: conditionally rotates right by (WIDTH/2 >> step).
// Ports:
//   din  : value entering the stage
//   step : stage index 0..AMT_W-1 (0 = largest rotation)
//   en   : apply the rotation when high, pass through otherwise
//   dout : stage output (combinational)
module rotr_stage
    import rotr_seq_pkg::*;
#(
    parameter int unsigned WIDTH = ROTR_WIDTH,
    parameter int unsigned AMT_W = ROTR_AMT_W
) (
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       step,
    input  logic             en,
    output logic [WIDTH-1:0] dout
);

    logic [AMT_W-1:0] sh;

    always_comb begin
        sh   = AMT_W'((WIDTH / 2) >> step);
        // A left shift by the full width yields zero, so sh=0 degenerates to a pass-through.
        dout = en ? ((din >> sh) | (din << (WIDTH - int'(sh)))) : din;
    end

endmodule

// File: rtl/rotr_seq.sv
// Multi-cycle rotate-right unit: rotates a right by b[AMT_W-1:0], one logarithmic
// stage per clock, with a start/busy/done handshake and a registered result.
// Ports:
//   clock  : system clock, rising edge
//   clear  : synchronous active-high reset, overrides everything
//   start  : request pulse, accepted in IDLE or DONE only
//   a      : operand, sampled at the accepting edge
//   b      : rotate amount, only b[AMT_W-1:0] is used
//   result : rotated value, held until the next operation completes
//   busy   : high while rotating
//   done   : one-cycle pulse, result valid in the same cycle
module rotr_seq
    import rotr_seq_pkg::*;
#(
    parameter int unsigned WIDTH = ROTR_WIDTH,
    parameter int unsigned AMT_W = ROTR_AMT_W
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    rotr_state_e      state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic [2:0]       step_q, step_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             stage_en;
    logic [WIDTH-1:0] stage_out;

    // Upper amount bits are deliberately ignored.
    logic unused_b;
    assign unused_b = ^b[WIDTH-1:AMT_W];

    // Stage k consumes amount bit AMT_W-1-k (MSB first: 16, 8, 4, 2, 1).
    always_comb begin
        stage_en = 1'b0;
        case (step_q)
            3'd0:    stage_en = amt_q[AMT_W-1];
            3'd1:    stage_en = amt_q[AMT_W-2];
            3'd2:    stage_en = amt_q[AMT_W-3];
            3'd3:    stage_en = amt_q[AMT_W-4];
            3'd4:    stage_en = amt_q[AMT_W-5];
            default: stage_en = 1'b0;
        endcase
    end

    rotr_stage #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_stage (
        .din  (work_q),
        .step (step_q),
        .en   (stage_en),
        .dout (stage_out)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        amt_d    = amt_q;
        step_d   = step_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = ROT;
                    work_d  = a;
                    amt_d   = b[AMT_W-1:0];
                    step_d  = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            ROT: begin
                work_d = stage_out;
                step_d = step_q + 3'd1;
                if (step_q == 3'(AMT_W - 1)) begin
                    // Last stage writes straight into result to keep latency fixed.
                    result_d = stage_out;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= IDLE;
            work_q   <= '0;
            amt_q    <= '0;
            step_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            amt_q    <= amt_d;
            step_q   <= step_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == ROT);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_rotr_seq.sv
module tb_rotr_seq;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        busy;
    logic        done;

    rotr_seq dut (
        .clock  (clock),
        .clear  (clear),
        .start  (start),
        .a      (a),
        .b      (b),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clock = ~clock;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t sb[$];

    // Reference: result bit i takes operand bit (i + n) mod 32.
    function automatic logic [31:0] rotr_ref(input logic [31:0] x, input logic [31:0] amt);
        logic [31:0] r;
        int          n;
        n = int'(amt % 32);
        for (int i = 0; i < 32; i++) r[i] = x[(i + n) % 32];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge: drive a request and record the expected completion.
    task automatic issue(input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] ex);
        start = 1'b1;
        a     = aa;
        b     = bb;
        sb.push_back('{res: ex, due: cyc + 6});
    endtask

    // Issues one operation and returns at the negedge of its done cycle.
    task automatic run_op(input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] ex,
                          input bit noise);
        issue(aa, bb, ex);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            if (noise && k < 6 && $urandom_range(0, 2) == 0) begin
                start = 1'b1;
                a     = $urandom;
                b     = $urandom;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            exp_t e;
            n_done++;
            chk("busy_with_done", {31'b0, busy}, 32'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 with result %h, expected no pulse (cycle %0d)",
                         result, cyc);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("done_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int          d0;
        logic [31:0] ra, rb;

        clear = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clock);
        chk("reset_result", result, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        clear = 1'b0;

        // Basic: exact busy/done timing.
        issue(32'h0000_0001, 32'd1, 32'h8000_0000);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            start = 1'b0;
            chk($sformatf("basic_busy_c%0d", k), {31'b0, busy}, {31'b0, (k < 6)});
            chk($sformatf("basic_done_c%0d", k), {31'b0, done}, {31'b0, (k == 6)});
        end
        @(negedge clock);

        // Directed amounts, including masking of b[31:5].
        run_op(32'h1234_5678, 32'd4,  32'h8123_4567, 1'b0); @(negedge clock);
        run_op(32'h1234_5678, 32'd16, 32'h5678_1234, 1'b0); @(negedge clock);
        run_op(32'h1234_5678, 32'd31, 32'h2468_ACF0, 1'b0); @(negedge clock);
        run_op(32'hDEAD_BEEF, 32'd0,  32'hDEAD_BEEF, 1'b0); @(negedge clock);
        run_op(32'hDEAD_BEEF, 32'd32, 32'hDEAD_BEEF, 1'b0); @(negedge clock);
        run_op(32'hDEAD_BEEF, 32'd37, 32'h7EF5_6DF7, 1'b0); @(negedge clock);

        // Start while busy is ignored; exactly one done follows.
        d0 = n_done;
        issue(32'h1234_5678, 32'd8, 32'h7812_3456);
        @(negedge clock); start = 1'b0;
        @(negedge clock); start = 1'b1; a = 32'hFFFF_FFFF; b = 32'd3;
        @(negedge clock); start = 1'b0; a = $urandom; b = $urandom;
        repeat (11) @(negedge clock);
        chk("ignore_busy_done_count", n_done - d0, 32'd1);

        // Back-to-back accept in the DONE cycle.
        run_op(32'hA5A5_0F0F, 32'd12, 32'hF0FA_5A50, 1'b0);
        chk("b2b_first_done", {31'b0, done}, 32'd1);
        chk("b2b_first_result", result, 32'hF0FA_5A50);
        issue(32'h0000_00FF, 32'd4, 32'hF000_000F);
        @(negedge clock);
        start = 1'b0;
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        chk("b2b_result_held", result, 32'hF0FA_5A50);
        repeat (5) @(negedge clock);
        chk("b2b_second_done", {31'b0, done}, 32'd1);
        @(negedge clock);

        // Clear mid-operation: discarded, no done, then normal operation.
        issue(32'hCAFE_F00D, 32'd9, 32'h0);
        @(negedge clock); start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1;
        sb.delete();
        @(negedge clock);
        chk("clear_busy", {31'b0, busy}, 32'd0);
        chk("clear_done", {31'b0, done}, 32'd0);
        chk("clear_result", result, 32'd0);
        clear = 1'b0;
        d0 = n_done;
        repeat (8) @(negedge clock);
        chk("clear_no_done", n_done - d0, 32'd0);
        run_op(32'hCAFE_F00D, 32'd9, rotr_ref(32'hCAFE_F00D, 32'd9), 1'b0);
        @(negedge clock);

        // Random operations with noise starts and random gaps (gap 0 = back-to-back).
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, rotr_ref(ra, rb), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (10) @(negedge clock);
        chk("pending_at_end", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
